// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: command-FIFO driven AHB-Lite single-transfer master.
// The data-phase timeout abort is built only when AHBM_TIMEOUT_EN is defined.
module ahb_cmd_master #(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        iClk,
  input  logic        iRsn,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic        iCmdWrite,
  input  logic [31:0] iCmdAddr,
  input  logic [31:0] iCmdWdata,
  output logic        oRspValid,
  output logic        oRspWrite,
  output logic [31:0] oRspRdata,
  output logic        oRspErr,
  output logic        oRspTimeout,
  output logic        oBusy,
  output logic        oHSEL,
  output logic [1:0]  oHTRANS,
  output logic        oHWRITE,
  output logic [31:0] oHADDR,
  output logic [31:0] oHWDATA,
  input  logic [31:0] iHRDATA,
  input  logic        iHREADY,
  input  logic [1:0]  iHRESP
);

  localparam int unsigned AW = $clog2(CMD_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 ||
      TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : gParamCheck
    $error("ahb_cmd_master: CMD_DEPTH must be a power of 2 >= 2, TIMEOUT_CYC in 1..255");
  end

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  cmd_t          fifoMem [CMD_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          fifoEmpty;
  logic          fifoFull;
  logic          push;
  logic          pop;
  cmd_t          headCmd;
  state_t        state;
  logic [31:0]   wdataLatch;

`ifdef AHBM_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC - 1);
  logic [7:0] toCnt;
`endif

  // Extra pointer MSB distinguishes full from empty when the indexes match.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign push      = iCmdValid && !fifoFull;
  assign pop       = !fifoEmpty && ((state == S_IDLE) || (state == S_RESP));
  assign headCmd   = fifoMem[rdPtr[AW-1:0]];
  assign oCmdReady = !fifoFull;
  assign oBusy     = !fifoEmpty || (state != S_IDLE);

  always_ff @(posedge iClk) begin
    if (push) begin
      fifoMem[wrPtr[AW-1:0]] <= {iCmdWrite, iCmdAddr, iCmdWdata};
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
    end
  end

  // Transfer sequencer: one NONSEQ per command, never pipelined.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state       <= S_IDLE;
      wdataLatch  <= '0;
      oHSEL       <= 1'b0;
      oHTRANS     <= HTRANS_IDLE;
      oHWRITE     <= 1'b0;
      oHADDR      <= '0;
      oHWDATA     <= '0;
      oRspValid   <= 1'b0;
      oRspWrite   <= 1'b0;
      oRspRdata   <= '0;
      oRspErr     <= 1'b0;
      oRspTimeout <= 1'b0;
`ifdef AHBM_TIMEOUT_EN
      toCnt       <= '0;
`endif
    end else begin
      oRspValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifoEmpty) state <= S_ADDR;
        end
        S_ADDR: begin
          if (iHREADY) begin
            state   <= S_DATA;
            oHSEL   <= 1'b0;
            oHTRANS <= HTRANS_IDLE;
            oHWDATA <= wdataLatch;
`ifdef AHBM_TIMEOUT_EN
            toCnt   <= '0;
`endif
          end
        end
        S_DATA: begin
          if (iHREADY) begin
            state       <= S_RESP;
            oRspValid   <= 1'b1;
            oRspWrite   <= oHWRITE;
            oRspRdata   <= oHWRITE ? 32'h0 : iHRDATA;
            oRspErr     <= (iHRESP != 2'b00);
            oRspTimeout <= 1'b0;
            oHWDATA     <= '0;
          end
`ifdef AHBM_TIMEOUT_EN
          else if (toCnt == TO_LIMIT) begin
            // Abort: a late slave response is never sampled after this.
            state       <= S_RESP;
            oRspValid   <= 1'b1;
            oRspWrite   <= oHWRITE;
            oRspRdata   <= '0;
            oRspErr     <= 1'b1;
            oRspTimeout <= 1'b1;
            oHWDATA     <= '0;
          end else begin
            toCnt <= toCnt + 8'd1;
          end
`endif
        end
        S_RESP: begin
          state <= fifoEmpty ? S_IDLE : S_ADDR;
        end
        default: state <= S_IDLE;
      endcase

      // Launch the address phase of the popped command.
      if (pop) begin
        oHSEL      <= 1'b1;
        oHTRANS    <= HTRANS_NONSEQ;
        oHWRITE    <= headCmd.write;
        oHADDR     <= headCmd.addr;
        wdataLatch <= headCmd.write ? headCmd.wdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: small AHB slave model plus a response scoreboard.
module tb_ahb_cmd_master;

  logic        iClk;
  logic        iRsn;
  logic        iCmdValid;
  logic        oCmdReady;
  logic        iCmdWrite;
  logic [31:0] iCmdAddr;
  logic [31:0] iCmdWdata;
  logic        oRspValid;
  logic        oRspWrite;
  logic [31:0] oRspRdata;
  logic        oRspErr;
  logic        oRspTimeout;
  logic        oBusy;
  logic        oHSEL;
  logic [1:0]  oHTRANS;
  logic        oHWRITE;
  logic [31:0] oHADDR;
  logic [31:0] oHWDATA;
  logic [31:0] iHRDATA;
  logic        iHREADY;
  logic [1:0]  iHRESP;

  ahb_cmd_master dut (
    .iClk(iClk), .iRsn(iRsn),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWrite(iCmdWrite),
    .iCmdAddr(iCmdAddr), .iCmdWdata(iCmdWdata),
    .oRspValid(oRspValid), .oRspWrite(oRspWrite), .oRspRdata(oRspRdata),
    .oRspErr(oRspErr), .oRspTimeout(oRspTimeout), .oBusy(oBusy),
    .oHSEL(oHSEL), .oHTRANS(oHTRANS), .oHWRITE(oHWRITE), .oHADDR(oHADDR),
    .oHWDATA(oHWDATA), .iHRDATA(iHRDATA), .iHREADY(iHREADY), .iHRESP(iHRESP)
  );

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Slave model controls
  logic        holdLow = 1'b0;
  int          waitStates = 0;
  logic [31:0] errAddr = 32'h7000_BAD0;
  logic [31:0] mem [16384];
  logic        dpActive = 1'b0;
  logic        dpWrite = 1'b0;
  logic [31:0] dpAddr = 32'h0;
  int          dpWait = 0;

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave bookkeeping on the active edge.
  always @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      dpActive <= 1'b0;
      dpWait   <= 0;
    end else begin
      if (dpActive && iHREADY) begin
        dpActive <= 1'b0;
        if (dpWrite && dpAddr != errAddr) mem[dpAddr[15:2]] <= oHWDATA;
      end else if (dpActive) begin
        dpWait <= dpWait + 1;
      end
      if (oHSEL && oHTRANS == 2'b10 && iHREADY) begin
        dpActive <= 1'b1;
        dpWrite  <= oHWRITE;
        dpAddr   <= oHADDR;
        dpWait   <= 0;
      end
    end
  end

  // Slave drives its outputs on the inactive edge.
  always @(negedge iClk) begin
    if (dpActive) begin
      iHREADY = !holdLow && (dpWait >= waitStates);
      iHRESP  = (dpAddr == errAddr) ? 2'b01 : 2'b00;
      iHRDATA = dpWrite ? 32'h0 : mem[dpAddr[15:2]];
    end else begin
      iHREADY = !holdLow;
      iHRESP  = 2'b00;
      iHRDATA = 32'h0;
    end
  end

  // Response monitor: every strobe must match the oldest expectation.
  always @(negedge iClk) begin
    if (iRsn && oRspValid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got write=%b rdata=%h err=%b, expected none (cycle %0d)",
                 oRspWrite, oRspRdata, oRspErr, cyc);
      end else begin
        mon = sbq.pop_front();
        chk("rsp_write", 32'(oRspWrite), 32'(mon.write));
        chk("rsp_rdata", oRspRdata, mon.rdata);
        chk("rsp_err", 32'(oRspErr), 32'(mon.err));
        chk("rsp_timeout", 32'(oRspTimeout), 32'(mon.tmo));
        if (mon.cyc >= 0) chk("rsp_cycle", 32'(cyc), 32'(mon.cyc));
      end
    end
  end

  task automatic expect_rsp(input logic w, input logic [31:0] rd, input logic e,
                            input logic t, input int c);
    exp_t x;
    x.write = w; x.rdata = rd; x.err = e; x.tmo = t; x.cyc = c;
    sbq.push_back(x);
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int pc);
    iCmdValid = 1'b1;
    iCmdWrite = w;
    iCmdAddr  = a;
    iCmdWdata = d;
    @(posedge iClk);
    #1;
    iCmdValid = 1'b0;
    pc = cyc;
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((oBusy || sbq.size() != 0) && n < 2000) begin
      @(posedge iClk);
      #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles, expected idle", nm, n);
      sbq.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hsel"}, 32'(oHSEL), 32'h0);
    chk({tag, "_htrans"}, 32'(oHTRANS), 32'h0);
    chk({tag, "_hwrite"}, 32'(oHWRITE), 32'h0);
    chk({tag, "_haddr"}, oHADDR, 32'h0);
    chk({tag, "_hwdata"}, oHWDATA, 32'h0);
    chk({tag, "_rspvalid"}, 32'(oRspValid), 32'h0);
    chk({tag, "_rspwrite"}, 32'(oRspWrite), 32'h0);
    chk({tag, "_rsprdata"}, oRspRdata, 32'h0);
    chk({tag, "_rsperr"}, 32'(oRspErr), 32'h0);
    chk({tag, "_rsptimeout"}, 32'(oRspTimeout), 32'h0);
    chk({tag, "_busy"}, 32'(oBusy), 32'h0);
    chk({tag, "_cmdready"}, 32'(oCmdReady), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int c0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    iRsn = 1'b0;
    iCmdValid = 1'b0;
    iCmdWrite = 1'b0;
    iCmdAddr = 32'h0;
    iCmdWdata = 32'h0;
    iHRDATA = 32'h0;
    iHREADY = 1'b1;
    iHRESP = 2'b00;
    repeat (3) @(negedge iClk);
    check_reset("rst");
    iRsn = 1'b1;
    @(posedge iClk);
    #1;
    check_reset("post_rst");

    // Zero-wait write
    push(1'b1, 32'h7000_8000, 32'hDEAD_BEEF, p);
    expect_rsp(1'b1, 32'h0, 1'b0, 1'b0, p + 3);
    to_cyc(p + 1);
    chk("t1_hsel", 32'(oHSEL), 32'h1);
    chk("t1_htrans", 32'(oHTRANS), 32'h2);
    chk("t1_haddr", oHADDR, 32'h7000_8000);
    chk("t1_hwrite", 32'(oHWRITE), 32'h1);
    to_cyc(p + 2);
    chk("t1_hwdata", oHWDATA, 32'hDEAD_BEEF);
    chk("t1_htrans_data", 32'(oHTRANS), 32'h0);
    wait_idle("t1");

    // Write then read with 3 wait states each
    waitStates = 3;
    push(1'b1, 32'h7000_803C, 32'h1234_5678, p);
    expect_rsp(1'b1, 32'h0, 1'b0, 1'b0, p + 6);
    push(1'b0, 32'h7000_803C, 32'h0, c0);
    expect_rsp(1'b0, 32'h1234_5678, 1'b0, 1'b0, p + 12);
    for (int k = 3; k <= 5; k++) begin
      to_cyc(p + k);
      chk("t2_hwdata_hold", oHWDATA, 32'h1234_5678);
      chk("t2_haddr_hold", oHADDR, 32'h7000_803C);
    end
    wait_idle("t2");
    waitStates = 0;

    // Fill the FIFO behind a stalled transfer
    holdLow = 1'b1;
    push(1'b1, 32'h7000_0000, 32'hA5A5_A5A5, p);
    to_cyc(p + 2);
    push(1'b1, 32'h7000_0010, 32'h1111_1111, c0);
    chk("t3_ready_1", 32'(oCmdReady), 32'h1);
    push(1'b0, 32'h7000_8000, 32'h0, c0);
    push(1'b1, 32'h7000_0018, 32'h2222_2222, c0);
    push(1'b0, 32'h7000_0010, 32'h0, c0);
    chk("t3_ready_full", 32'(oCmdReady), 32'h0);
    push(1'b1, 32'h7000_0020, 32'h5555_5555, c0);
    chk("t3_ready_still_full", 32'(oCmdReady), 32'h0);
    chk("t3_busy", 32'(oBusy), 32'h1);
    c0 = cyc;
    expect_rsp(1'b1, 32'h0, 1'b0, 1'b0, c0 + 2);
    expect_rsp(1'b1, 32'h0, 1'b0, 1'b0, c0 + 5);
    expect_rsp(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, c0 + 8);
    expect_rsp(1'b1, 32'h0, 1'b0, 1'b0, c0 + 11);
    expect_rsp(1'b0, 32'h1111_1111, 1'b0, 1'b0, c0 + 14);
    holdLow = 1'b0;
    wait_idle("t3");
    push(1'b0, 32'h7000_0020, 32'h0, p);
    expect_rsp(1'b0, 32'h0, 1'b0, 1'b0, p + 3);
    wait_idle("t3_dropped");

    // Two-cycle ERROR response followed by normal traffic
    waitStates = 1;
    push(1'b0, errAddr, 32'h0, p);
    expect_rsp(1'b0, 32'h0, 1'b1, 1'b0, p + 4);
    push(1'b1, 32'h7000_0030, 32'h0BAD_F00D, c0);
    expect_rsp(1'b1, 32'h0, 1'b0, 1'b0, p + 8);
    push(1'b0, 32'h7000_0030, 32'h0, c0);
    expect_rsp(1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, p + 12);
    wait_idle("t4");

`ifdef AHBM_TIMEOUT_EN
    // Data phase stalled past the timeout limit
    waitStates = 1000;
    push(1'b0, 32'h7000_0040, 32'h0, p);
    expect_rsp(1'b0, 32'h0, 1'b1, 1'b1, p + 257);
    wait_idle("t5");
    chk("t5_hsel_idle", 32'(oHSEL), 32'h0);
    chk("t5_htrans_idle", 32'(oHTRANS), 32'h0);
    waitStates = 0;
    repeat (2) @(posedge iClk);
    #1;
`endif

    // Reset during a stalled write data phase
    waitStates = 2;
    push(1'b1, 32'h7000_0050, 32'hCAFE_F00D, p);
    to_cyc(p + 3);
    chk("t6_hwdata_pre", oHWDATA, 32'hCAFE_F00D);
    #2;
    iRsn = 1'b0;
    #1;
    check_reset("t6_async");
    repeat (2) @(negedge iClk);
    iRsn = 1'b1;
    waitStates = 0;
    @(posedge iClk);
    #1;
    chk("t6_busy_after", 32'(oBusy), 32'h0);
    chk("t6_ready_after", 32'(oCmdReady), 32'h1);
    push(1'b0, 32'h7000_0050, 32'h0, p);
    expect_rsp(1'b0, 32'h0, 1'b0, 1'b0, p + 3);
    wait_idle("t6");

    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
